uart_tx_arb: RTL and testbench

Round-robin arbiter that shares the single `uart_tx` serializer among up to `NREQ` logger byte sources. It grants the transmitter to one requester at a time and issues the one-cycle `din_rdy` pulse with a held data byte. It waits for `tx_done` before sending the next byte, and it keeps the grant for a packet until the requester signals last or the burst limit is reached. It sits between the logger channel formatters and `uart_tx`.

---
 rtl/uart_tx_arb_if.sv | 28 ++
 rtl/uart_tx_arb.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// Requester/serializer signal bundle for uart_tx_arb.
// slave modport is the arbiter's view, master modport is the requester+uart_tx side.
interface uart_tx_arb_if #(
    parameter int NREQ = 4
);
    // Handshakes: req[i] is a level valid held with data/last until ack[i], a one-cycle
    // accept; tx_rdy is a one-cycle strobe to uart_tx with tx_byte held until tx_done.
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   last;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              tx_rdy;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              busy;
    logic              err;

    modport slave (
        input  req, last, data, tx_done,
        output ack, grant, tx_rdy, tx_byte, busy, err
    );

    modport master (
        output req, last, data, tx_done,
        input  ack, grant, tx_rdy, tx_byte, busy, err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte sources, with packet bursts.
// Optional WAIT watchdog is built when UART_TX_ARB_WDOG_EN is defined.
module uart_tx_arb #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_arb_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      MAX_B    = 8'(MAX_BURST);
    localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   w_q, w_d;
    logic [PW-1:0]   win, cand, nxt_ptr;
    logic            found;
    logic [7:0]      burst_q, burst_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            last_q, last_d;
    logic            tx_rdy_q, tx_rdy_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] grant_oh;
    logic            wd_fire;

    // First requesting index at or above the pointer, wrapping modulo NREQ.
    always_comb begin : winner_search
        found = 1'b0;
        win   = ptr_q;
        cand  = ptr_q;
        for (int off = 0; off < NREQ; off++) begin
            if (int'(ptr_q) + off >= NREQ)
                cand = PW'(int'(ptr_q) + off - NREQ);
            else
                cand = PW'(int'(ptr_q) + off);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign nxt_ptr = (w_q == LAST_IDX) ? '0 : w_q + PW'(1);

    always_comb begin : grant_decode
        grant_oh = '0;
        if (state_q != IDLE) grant_oh[w_q] = 1'b1;
    end

`ifdef UART_TX_ARB_WDOG_EN
    localparam logic [19:0] WD_LIM = 20'(TIMEOUT - 1);
    logic [19:0] wd_q, wd_d;

    // Held at zero outside WAIT, so every entry into WAIT starts a fresh count.
    always_comb begin : wd_next
        wd_d = wd_q + 20'd1;
        if (state_q != WAIT) wd_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end

    assign wd_fire = (wd_q == WD_LIM);
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin : fsm_next
        state_d   = state_q;
        ptr_d     = ptr_q;
        w_d       = w_q;
        burst_d   = burst_q;
        last_d    = last_q;
        tx_byte_d = tx_byte_q;
        tx_rdy_d  = 1'b0;
        ack_d     = '0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    w_d     = win;
                    burst_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.req[w_q]) begin
                    tx_byte_d  = bus.data[{w_q, 3'b000} +: 8];
                    tx_rdy_d   = 1'b1;
                    ack_d[w_q] = 1'b1;
                    last_d     = bus.last[w_q];
                    burst_d    = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;
                    state_d    = WAIT;
                end else begin
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end
            end
            WAIT: begin
                if (bus.tx_done) begin
                    if (last_q || burst_q >= MAX_B) begin
                        state_d = IDLE;
                        ptr_d   = nxt_ptr;
                    end else begin
                        state_d = SEND;
                    end
                end else if (wd_fire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            w_q       <= '0;
            burst_q   <= '0;
            last_q    <= 1'b0;
            tx_byte_q <= 8'h00;
            tx_rdy_q  <= 1'b0;
            ack_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            w_q       <= w_d;
            burst_q   <= burst_d;
            last_q    <= last_d;
            tx_byte_q <= tx_byte_d;
            tx_rdy_q  <= tx_rdy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.grant   = grant_oh;
    assign bus.tx_rdy  = tx_rdy_q;
    assign bus.tx_byte = tx_byte_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.err     = err_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and randomized bench for uart_tx_arb with a packet-level round-robin model.
// Watchdog checks follow UART_TX_ARB_WDOG_EN as the design does.
module tb_uart_tx_arb;
    localparam int NREQ = 4;
    localparam int MAXB = 16;
    localparam int TMO  = 1000;

    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;

    uart_tx_arb_if #(.NREQ(NREQ)) bus ();

    uart_tx_arb #(.NREQ(NREQ), .MAX_BURST(MAXB), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bench state ----------------
    logic [9:0] exp_q[$];
    int         total, bad;
    logic       auto_src, auto_uart, scb_on, inflight, done_prev;
    logic [7:0] held_byte;
    int         udly, ack_cnt, done_cnt, model_ptr;
    logic [7:0] smem [NREQ][32];
    logic       slst [NREQ][32];
    int         slen [NREQ];
    int         spos [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        auto_src    = 1'b0;
        auto_uart   = 1'b0;
        scb_on      = 1'b0;
        inflight    = 1'b0;
        udly        = 0;
        bus.req     = '0;
        bus.last    = '0;
        bus.data    = '0;
        bus.tx_done = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            slen[i] = 0;
            spos[i] = 0;
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drive_src();
        for (int i = 0; i < NREQ; i++) begin
            if (spos[i] < slen[i]) begin
                bus.req[i]          = 1'b1;
                bus.data[8*i +: 8]  = smem[i][spos[i]];
                bus.last[i]         = slst[i][spos[i]];
            end else begin
                bus.req[i]          = 1'b0;
                bus.data[8*i +: 8]  = 8'h00;
                bus.last[i]         = 1'b0;
            end
        end
    endtask

    // One clock: check hold before the edge, sample 1 time unit after it, then
    // let the emulated requesters and serializer react for the next edge.
    task automatic step();
        logic [9:0] e;
        done_prev = bus.tx_done;
        if (done_prev && inflight) chk("tx_byte_hold", bus.tx_byte, held_byte);
        @(posedge clk);
        #1;
        if (done_prev) begin
            inflight = 1'b0;
            done_cnt++;
        end
        if (bus.tx_rdy) begin
            ack_cnt++;
            inflight  = 1'b1;
            held_byte = bus.tx_byte;
            if (scb_on) begin
                chk("scb_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("scb_owner", bus.ack, 4'b0001 << e[9:8]);
                    chk("scb_byte", bus.tx_byte, e[7:0]);
                    chk("scb_err", bus.err, 1'b0);
                end
            end
        end
        if (auto_src) begin
            for (int i = 0; i < NREQ; i++)
                if (bus.ack[i]) spos[i]++;
            drive_src();
        end
        if (auto_uart) begin
            bus.tx_done = 1'b0;
            if (bus.tx_rdy) udly = $urandom_range(1, 5);
            else if (udly > 0) begin
                udly--;
                if (udly == 0) bus.tx_done = 1'b1;
            end
        end
    endtask

    // Packet-level reference: each grant goes to the next non-empty source after
    // the last owner and runs until a last byte, the burst limit, or the source empties.
    task automatic build_exp();
        int   mp [NREQ];
        int   w, n;
        logic any, is_last;
        for (int i = 0; i < NREQ; i++) mp[i] = spos[i];
        while (1'b1) begin
            any = 1'b0;
            w   = 0;
            for (int off = 0; off < NREQ; off++) begin
                int k;
                k = (model_ptr + off) % NREQ;
                if (!any && mp[k] < slen[k]) begin
                    any = 1'b1;
                    w   = k;
                end
            end
            if (!any) break;
            n = 0;
            do begin
                exp_q.push_back({2'(w), smem[w][mp[w]]});
                is_last = slst[w][mp[w]];
                mp[w]++;
                n++;
            end while (!is_last && n < MAXB && mp[w] < slen[w]);
            model_ptr = (w + 1) % NREQ;
        end
    endtask

    function automatic logic drained();
        logic d;
        d = (exp_q.size() == 0) && !bus.busy && !inflight;
        for (int i = 0; i < NREQ; i++)
            if (spos[i] < slen[i]) d = 1'b0;
        return d;
    endfunction

    task automatic load_random();
        for (int i = 0; i < NREQ; i++) begin
            slen[i] = $urandom_range(0, 24);
            spos[i] = 0;
            for (int j = 0; j < slen[i]; j++) begin
                smem[i][j] = 8'($urandom_range(0, 255));
                slst[i][j] = ($urandom_range(0, 7) == 0);
            end
            if (slen[i] > 0) slst[i][slen[i]-1] = 1'b1;
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] alog [4];
        int         na, nexp, n;
        logic       t3_seen, err_seen;

        total = 0;
        bad   = 0;
        ack_cnt  = 0;
        done_cnt = 0;
        held_byte = 8'h00;
        reset_dut();

        // Reset values
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_ack", bus.ack, 4'b0000);
        chk("rst_tx_rdy", bus.tx_rdy, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_tx_byte", bus.tx_byte, 8'h00);

        // Single byte from requester 2
        bus.req            = 4'b0100;
        bus.last           = 4'b0100;
        bus.data[23:16]    = 8'hA5;
        step();
        chk("t1_grant", bus.grant, 4'b0100);
        chk("t1_no_rdy_yet", bus.tx_rdy, 1'b0);
        chk("t1_busy", bus.busy, 1'b1);
        step();
        chk("t1_tx_rdy", bus.tx_rdy, 1'b1);
        chk("t1_ack", bus.ack, 4'b0100);
        chk("t1_tx_byte", bus.tx_byte, 8'hA5);
        bus.req = 4'b0000;
        step();
        chk("t1_rdy_single", bus.tx_rdy, 1'b0);
        chk("t1_ack_single", bus.ack, 4'b0000);
        step();
        step();
        chk("t1_hold", bus.tx_byte, 8'hA5);
        chk("t1_grant_held", bus.grant, 4'b0100);
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("t1_release_grant", bus.grant, 4'b0000);
        chk("t1_release_busy", bus.busy, 1'b0);

        // Requester drops in the cycle its grant appears
        reset_dut();
        bus.req  = 4'b0100;
        bus.last = 4'b0100;
        step();
        chk("t4_grant", bus.grant, 4'b0100);
        bus.req = 4'b0000;
        step();
        chk("t4_no_rdy", bus.tx_rdy, 1'b0);
        chk("t4_no_ack", bus.ack, 4'b0000);
        chk("t4_idle", bus.busy, 1'b0);
        chk("t4_grant_off", bus.grant, 4'b0000);
        bus.req  = 4'b1101;
        bus.last = 4'b1101;
        step();
        chk("t4_ptr_is_3", bus.grant, 4'b1000);
        bus.req = 4'b0000;
        step();
        step();
        chk("t4_back_idle", bus.busy, 1'b0);

        // Two continuous requesters alternate
        reset_dut();
        bus.req   = 4'b1001;
        bus.last  = 4'b1001;
        bus.data  = 32'h11000022;
        auto_uart = 1'b1;
        done_cnt  = 0;
        na        = 0;
        for (int c = 0; c < 200 && done_cnt < 4; c++) begin
            step();
            if (bus.ack != 4'b0000) begin
                if (na < 4) alog[na] = bus.ack;
                na++;
            end
        end
        chk("t2_dones", done_cnt, 4);
        chk("t2_acks_per_done", na, 4);
        chk("t2_order0", alog[0], 4'b0001);
        chk("t2_order1", alog[1], 4'b1000);
        chk("t2_order2", alog[2], 4'b0001);
        chk("t2_order3", alog[3], 4'b1000);

        // Burst limit on a 20-byte packet without last
        reset_dut();
        slen[1] = 20;
        for (int j = 0; j < 20; j++) begin
            smem[1][j] = 8'($urandom_range(0, 255));
            slst[1][j] = 1'b0;
        end
        model_ptr = 0;
        build_exp();
        auto_src  = 1'b1;
        auto_uart = 1'b1;
        scb_on    = 1'b1;
        ack_cnt   = 0;
        t3_seen   = 1'b0;
        drive_src();
        for (int c = 0; c < 1000 && !drained(); c++) begin
            step();
            if (done_prev && ack_cnt == 16 && !t3_seen) begin
                t3_seen = 1'b1;
                chk("t3_release_grant", bus.grant, 4'b0000);
                chk("t3_release_busy", bus.busy, 1'b0);
                step();
                chk("t3_regrant", bus.grant, 4'b0010);
            end
        end
        chk("t3_drained", drained(), 1'b1);
        chk("t3_burst_release_seen", t3_seen, 1'b1);
        chk("t3_acks", ack_cnt, 20);

        // Random rounds, pointer state carried between rounds
        for (int r = 0; r < 3; r++) begin
            load_random();
            build_exp();
            nexp     = exp_q.size();
            ack_cnt  = 0;
            done_cnt = 0;
            drive_src();
            for (int c = 0; c < 4000 && !drained(); c++) step();
            chk("rnd_drained", drained(), 1'b1);
            chk("rnd_acks", ack_cnt, nexp);
            chk("rnd_one_done_per_ack", done_cnt, ack_cnt);
        end

        // Serializer never completes
        reset_dut();
        bus.req         = 4'b0001;
        bus.last        = 4'b0001;
        bus.data[7:0]   = 8'h3C;
        step();
        step();
        chk("t5_tx_rdy", bus.tx_rdy, 1'b1);
        bus.req  = 4'b0000;
        n        = 0;
        err_seen = 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
        while (n < 1100 && !err_seen) begin
            step();
            n++;
            err_seen = bus.err;
        end
        chk("t5_wdog_cycles", n, TMO);
        chk("t5_wdog_grant", bus.grant, 4'b0000);
        step();
        chk("t5_err_one_cycle", bus.err, 1'b0);
        chk("t5_idle_after", bus.busy, 1'b0);
`else
        while (n < 1100) begin
            step();
            n++;
            if (bus.err) err_seen = 1'b1;
        end
        chk("t5_no_err", err_seen, 1'b0);
        chk("t5_grant_kept", bus.grant, 4'b0001);
        chk("t5_busy_kept", bus.busy, 1'b1);
`endif

        // Asynchronous reset in WAIT, pointer returns to 0
        reset_dut();
        bus.req          = 4'b1000;
        bus.last         = 4'b1000;
        bus.data[31:24]  = 8'h77;
        step();
        chk("t6_grant3", bus.grant, 4'b1000);
        step();
        chk("t6_byte", bus.tx_byte, 8'h77);
        bus.req = 4'b0000;
        step();
        step();
        chk("t6_busy_wait", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("t6_async_clear", {bus.grant, bus.ack, bus.tx_rdy, bus.busy, bus.err, bus.tx_byte}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        inflight = 1'b0;
        bus.req  = 4'b1001;
        bus.last = 4'b1001;
        step();
        chk("t6_ptr_zero", bus.grant, 4'b0001);
        bus.req = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
